// File: rtl/vend_autoplay.sv
// vend_autoplay: scripted customer for the vending machine front panel (coin/select presses, LED readback).
// Optional watchdog on the wait states: define VEND_AUTOPLAY_TIMEOUT_EN.
module vend_autoplay #(
    parameter int unsigned PRESS_CYCLES   = 2_500_000,
    parameter int unsigned GAP_CYCLES     = 2_500_000,
    parameter int unsigned COINS_PER_VEND = 1,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] n_vends,
    input  logic       led_ready,
    input  logic       led_busy,
    input  logic       led_done,
    input  logic       led_error,
    output logic       btn_coin,
    output logic       btn_select,
    output logic       active,
    output logic       run_done,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt,
    output logic       timeout_flag
);

    localparam int unsigned TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [4:0]    COINS      = 5'(COINS_PER_VEND);

    typedef enum logic [2:0] {
        IDLE, WAIT_READY, PRESS_COIN, GAP_COIN, PRESS_SEL, WAIT_RESULT, FINISH
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    coin_idx;
    logic [7:0]    vend_idx;
    logic [7:0]    n_latched;
    logic          wd_expired;
    logic          wait_exit;
    logic          last_vend;
    logic          unused_busy;

    assign unused_busy = led_busy;
    assign last_vend   = (vend_idx + 8'd1) == n_latched;
    assign wait_exit   = ((state == WAIT_READY) && (led_ready || wd_expired)) ||
                         ((state == WAIT_RESULT) && (led_done || led_error || wd_expired));

`ifdef VEND_AUTOPLAY_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;

    assign wd_expired = ((state == WAIT_READY) || (state == WAIT_RESULT)) &&
                        (wd == WW'(TIMEOUT_CYCLES - 1));

    // Leaving a wait state (including WAIT_RESULT -> WAIT_READY) restarts the count.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n)
            wd <= '0;
        else if (((state == WAIT_READY) || (state == WAIT_RESULT)) && !wait_exit)
            wd <= wd + WW'(1);
        else
            wd <= '0;
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            coin_idx     <= '0;
            vend_idx     <= '0;
            n_latched    <= '0;
            btn_coin     <= 1'b0;
            btn_select   <= 1'b0;
            active       <= 1'b0;
            run_done     <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !run_done) begin
                        n_latched    <= n_vends;
                        vend_idx     <= '0;
                        pass_cnt     <= '0;
                        fail_cnt     <= '0;
                        timeout_flag <= 1'b0;
                        if (n_vends == 8'd0) begin
                            run_done <= 1'b1;
                        end else begin
                            active <= 1'b1;
                            state  <= WAIT_READY;
                        end
                    end
                end
                WAIT_READY: begin
                    if (led_ready) begin
                        btn_coin <= 1'b1;
                        timer    <= '0;
                        coin_idx <= '0;
                        state    <= PRESS_COIN;
                    end else if (wd_expired) begin
                        timeout_flag <= 1'b1;
                        fail_cnt     <= fail_cnt + 8'd1;
                        vend_idx     <= vend_idx + 8'd1;
                        state        <= last_vend ? FINISH : WAIT_READY;
                    end
                end
                PRESS_COIN: begin
                    if (timer == PRESS_LAST) begin
                        btn_coin <= 1'b0;
                        timer    <= '0;
                        state    <= GAP_COIN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP_COIN: begin
                    if (timer == GAP_LAST) begin
                        timer    <= '0;
                        coin_idx <= coin_idx + 4'd1;
                        if (({1'b0, coin_idx} + 5'd1) < COINS) begin
                            btn_coin <= 1'b1;
                            state    <= PRESS_COIN;
                        end else begin
                            btn_select <= 1'b1;
                            state      <= PRESS_SEL;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                PRESS_SEL: begin
                    if (timer == PRESS_LAST) begin
                        btn_select <= 1'b0;
                        timer      <= '0;
                        state      <= WAIT_RESULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_RESULT: begin
                    if (led_done || led_error || wd_expired) begin
                        if (led_error) begin
                            fail_cnt <= fail_cnt + 8'd1;
                        end else if (led_done) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end else begin
                            timeout_flag <= 1'b1;
                            fail_cnt     <= fail_cnt + 8'd1;
                        end
                        vend_idx <= vend_idx + 8'd1;
                        state    <= last_vend ? FINISH : WAIT_READY;
                    end
                end
                FINISH: begin
                    run_done <= 1'b1;
                    active   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
